pipeline_register: RTL
======================

Name: pipeline_register

Overview:
Parametrised multi-stage pipeline register with per-stage valid bits, global advance enable, synchronous flush and an occupancy count. It succeeds the single-bit enabled flip-flop and becomes the standard inter-stage latch for processor pipelines (IF/ID, ID/EX, EX/MEM, MEM/WB). Stall is expressed through ena and squash through flush.

Parameters:
WIDTH, 32, data bits per stage (>=1)
DEPTH, 1, number of register stages between d and q (>=1)
RESET_VAL, 0, WIDTH-bit value loaded into every stage on reset, flush, or bubble
CW, $clog2(DEPTH+1), width of the count port (localparam, not overridable)

Ports:
clk  in  1  clock; all state changes on the rising edge
aclr_n  in  1  asynchronous clear, active-low
ena  in  1  advance enable; 1 = pipeline shifts one stage, 0 = hold (stall)
flush  in  1  synchronous squash of all stages
in_valid  in  1  d carries a real instruction/datum
d  in  WIDTH  stage-0 input data
q  out  WIDTH  data of the last stage (DEPTH-1)
out_valid  out  1  valid bit of the last stage
count  out  CW  number of stages currently holding valid data, 0..DEPTH

Behaviour:
- Reset: aclr_n=0 immediately (no clock needed) sets every stage's data to RESET_VAL and every valid bit to 0. Therefore q=RESET_VAL, out_valid=0, count=0. Reset dominates all other inputs. Deasserting reset mid-stream resumes normal operation from the empty state on the next edge.
- Priority at each rising edge (aclr_n=1): flush > ena > hold.
- flush=1: all valid bits are cleared to 0, all data is set to RESET_VAL, and count=0 after the edge. This applies regardless of ena and in_valid; the input at that edge is discarded.
- ena=1 and flush=0: stage 0 takes d and in_valid; stage i takes stage i-1 (data and valid) for i=1..DEPTH-1. The last stage's old contents leave the block.
- Bubble rule: a stage that receives valid=0 loads RESET_VAL as its data, never stale or undriven data. If in_valid=0, stage 0 gets RESET_VAL whatever is on d.
- ena=0 and flush=0: all stages hold data and valid; count holds.
- Latency: a datum presented with ena=1 on edge k appears at q/out_valid after edge k+DEPTH-1, provided ena=1 on every intervening edge. Each edge with ena=0 adds one cycle.
- count is a registered counter, not a combinational popcount:
  - ena=1: count_next = count + in_valid - last_stage_valid.
  - flush: 0.
  - hold: unchanged.
  - Invariant: count always equals the popcount of the valid bits. Never exceeds DEPTH, never underflows.
- Full pipe with ena=1 and in_valid=1: one entry enters and one exits, so count stays at DEPTH. There is no backpressure output; the consumer must stall via ena.
- q and out_valid are driven directly from the last-stage registers (no combinational path from d).
- DEPTH=1 with in_valid tied to 1 and flush tied to 0 is functionally the old enabled flip-flop generalised to WIDTH bits.

Test Plan:
1. Reset: WIDTH=8, DEPTH=3, RESET_VAL=8'hA5. Drive aclr_n=0 mid-cycle -> q=8'hA5, out_valid=0, count=0 immediately, before any clock edge.
2. Fill/latency: ena=1, in_valid=1, d=1,2,3,4 on consecutive edges.
   - out_valid rises after edge 3 with q=1, then q=2,3,4 on the following edges.
   - count reads 1,2,3,3.
3. Stall: pipe full {1,2,3}, ena=0 for 4 edges while d changes -> q=1 and count=3 hold throughout. Then ena=1 resumes with q=2.
4. Bubbles: inputs valid 7, invalid 9, valid 8 -> q sequence is 7, then RESET_VAL with out_valid=0, then 8. count never exceeds 2.
5. Flush priority: pipe full, flush=1 with ena=1, in_valid=1, d=55 -> after the edge, count=0, out_valid=0, q=RESET_VAL, and 55 is never output.
6. Async reset mid-stream: aclr_n pulsed low between edges while count=2 -> immediate clear. After release, d=66 is valid at q 3 edges later.

Source files
------------

// File: rtl/pipeline_register.sv
// pipeline_register
//   Multi-stage pipeline latch with per-stage valid bits, a global advance
//   enable (stall), a synchronous flush (squash) and a registered occupancy
//   count. Stages that receive a bubble load RESET_VAL, not stale data.
//
// Ports
//   clk        rising-edge clock
//   aclr_n     asynchronous clear, active low (all stages -> RESET_VAL, invalid)
//   ena        1 = advance one stage, 0 = hold
//   flush      synchronous clear of all stages (wins over ena)
//   in_valid   d carries a real datum
//   d          stage-0 input data
//   q          last-stage data (registered)
//   out_valid  last-stage valid bit (registered)
//   count      number of valid stages, 0..DEPTH
`timescale 1ns/1ps
module pipeline_register #(
    parameter int                 WIDTH     = 32,
    parameter int                 DEPTH     = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    localparam int                CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             aclr_n,
    input  logic             ena,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             out_valid,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [CW-1:0]    r_count;

    // Per-stage shift inputs: stage 0 from the port, others from the
    // previous stage. Bubbles are replaced with RESET_VAL here.
    logic [WIDTH-1:0] w_din  [DEPTH];
    logic [DEPTH-1:0] w_vin;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign w_vin[gi] = in_valid;
                assign w_din[gi] = in_valid ? d : RESET_VAL;
            end else begin : g_rest
                assign w_vin[gi] = r_vld[gi-1];
                assign w_din[gi] = r_vld[gi-1] ? r_data[gi-1] : RESET_VAL;
            end
        end
    endgenerate

    // One entry in, last stage's entry out; the two cancel on a full pipe.
    logic [CW-1:0] w_count_nxt;
    assign w_count_nxt = r_count + CW'(in_valid) - CW'(r_vld[DEPTH-1]);

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            for (int i = 0; i < DEPTH; i++) r_data[i] <= RESET_VAL;
            r_vld   <= '0;
            r_count <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) r_data[i] <= RESET_VAL;
            r_vld   <= '0;
            r_count <= '0;
        end else if (ena) begin
            for (int i = 0; i < DEPTH; i++) r_data[i] <= w_din[i];
            r_vld   <= w_vin;
            r_count <= w_count_nxt;
        end
    end

    assign q         = r_data[DEPTH-1];
    assign out_valid = r_vld[DEPTH-1];
    assign count     = r_count;

endmodule
